// File: rtl/lift_pkg.sv
// rtl/lift_pkg.sv - shared call-state type and default parameters for hall call logic
package lift_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PENDING  = 2'd1,
        ASSIGNED = 2'd2,
        RETRY    = 2'd3
    } call_state_t;

    localparam int DEF_N_FLOORS        = 12;
    localparam int DEF_DEBOUNCE_CYCLES = 4;
    localparam int DEF_ASSIGN_TIMEOUT  = 64;

endpackage

// File: rtl/hall_call_cell.sv
// rtl/hall_call_cell.sv - one hall call: synchronizer, debouncer, call FSM and retry timer
module hall_call_cell
    import lift_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int ASSIGN_TIMEOUT  = DEF_ASSIGN_TIMEOUT
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_btn,
    input  logic i_status,
    output logic o_rqst,
    output logic o_lamp
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TW = $clog2(ASSIGN_TIMEOUT);
    localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES);
    localparam logic [TW-1:0] TMAX = TW'(ASSIGN_TIMEOUT - 1);

    logic [1:0]    r_sync;
    logic [CW-1:0] r_cnt;
    logic          r_deb;
    logic          r_deb_q;
    call_state_t   r_state;
    logic [TW-1:0] r_timer;
    logic          r_rqst;
    logic          r_lamp;

    logic          w_level;
    logic          w_press;
    call_state_t   w_next;
    logic [TW-1:0] w_timer_next;

    assign w_level = (r_cnt == CMAX);
    assign w_press = r_deb & ~r_deb_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_sync  <= '0;
            r_cnt   <= '0;
            r_deb   <= 1'b0;
            r_deb_q <= 1'b0;
            r_state <= IDLE;
            r_timer <= '0;
            r_rqst  <= 1'b0;
            r_lamp  <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], i_btn};
            if (!r_sync[1])
                r_cnt <= '0;
            else if (r_cnt != CMAX)
                r_cnt <= r_cnt + 1'b1;
            r_deb   <= w_level;
            r_deb_q <= r_deb;
            r_state <= w_next;
            r_timer <= w_timer_next;
            // outputs decoded from next state so they leave flops aligned with r_state
            r_rqst  <= (w_next == PENDING);
            r_lamp  <= (w_next != IDLE);
        end
    end

    always_comb begin
        w_next       = r_state;
        w_timer_next = r_timer;
        case (r_state)
            IDLE: begin
                if (w_press) begin
                    w_next       = i_status ? ASSIGNED : PENDING;
                    w_timer_next = '0;
                end
            end
            PENDING: begin
                if (i_status) begin
                    w_next       = ASSIGNED;
                    w_timer_next = '0;
                end else if (r_timer == TMAX) begin
                    w_next       = RETRY;
                    w_timer_next = '0;
                end else begin
                    w_timer_next = r_timer + 1'b1;
                end
            end
            ASSIGNED: begin
                if (!i_status)
                    w_next = IDLE;
            end
            RETRY: begin
                w_next       = i_status ? ASSIGNED : PENDING;
                w_timer_next = '0;
            end
            default: w_next = IDLE;
        endcase
    end

    assign o_rqst = r_rqst;
    assign o_lamp = r_lamp;

endmodule

// File: rtl/hall_call_register.sv
// rtl/hall_call_register.sv - per-floor UP/DOWN hall call registration with arbiter handshake
module hall_call_register
    import lift_pkg::*;
#(
    parameter int N_FLOORS        = DEF_N_FLOORS,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int ASSIGN_TIMEOUT  = DEF_ASSIGN_TIMEOUT
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [N_FLOORS-1:0] up_btn,
    input  logic [N_FLOORS-1:0] dn_btn,
    input  logic [N_FLOORS-1:0] up_status,
    input  logic [N_FLOORS-1:0] dn_status,
    output logic [N_FLOORS-1:0] up_rqst,
    output logic [N_FLOORS-1:0] dn_rqst,
    output logic [N_FLOORS-1:0] up_lamp,
    output logic [N_FLOORS-1:0] dn_lamp
);

    // top floor has no UP call and ground floor has no DOWN call
    logic w_unused_bound;
    assign w_unused_bound = &{1'b0, up_btn[N_FLOORS-1], up_status[N_FLOORS-1],
                              dn_btn[0], dn_status[0]};

    for (genvar f = 0; f < N_FLOORS; f++) begin : g_floor
        if (f == N_FLOORS - 1) begin : g_up_tie
            assign up_rqst[f] = 1'b0;
            assign up_lamp[f] = 1'b0;
        end else begin : g_up
            hall_call_cell #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .ASSIGN_TIMEOUT  (ASSIGN_TIMEOUT)
            ) u_up (
                .clk      (clk),
                .reset_n  (reset_n),
                .i_btn    (up_btn[f]),
                .i_status (up_status[f]),
                .o_rqst   (up_rqst[f]),
                .o_lamp   (up_lamp[f])
            );
        end

        if (f == 0) begin : g_dn_tie
            assign dn_rqst[f] = 1'b0;
            assign dn_lamp[f] = 1'b0;
        end else begin : g_dn
            hall_call_cell #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .ASSIGN_TIMEOUT  (ASSIGN_TIMEOUT)
            ) u_dn (
                .clk      (clk),
                .reset_n  (reset_n),
                .i_btn    (dn_btn[f]),
                .i_status (dn_status[f]),
                .o_rqst   (dn_rqst[f]),
                .o_lamp   (dn_lamp[f])
            );
        end
    end

endmodule

// File: tb/tb_hall_call_register.sv
// tb/tb_hall_call_register.sv - randomized scoreboard bench for hall_call_register
module tb_hall_call_register;
    import lift_pkg::*;

    localparam int N  = DEF_N_FLOORS;
    localparam int DB = DEF_DEBOUNCE_CYCLES;
    localparam int TO = DEF_ASSIGN_TIMEOUT;
    localparam int NC = 2 * N;

    logic         clk = 1'b0;
    logic         reset_n;
    logic [N-1:0] up_btn, dn_btn, up_status, dn_status;
    logic [N-1:0] up_rqst, dn_rqst, up_lamp, dn_lamp;

    always #5 clk = ~clk;

    hall_call_register dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .up_btn    (up_btn),
        .dn_btn    (dn_btn),
        .up_status (up_status),
        .dn_status (dn_status),
        .up_rqst   (up_rqst),
        .dn_rqst   (dn_rqst),
        .up_lamp   (up_lamp),
        .dn_lamp   (dn_lamp)
    );

    typedef struct {
        logic [N-1:0] ur;
        logic [N-1:0] dr;
        logic [N-1:0] ul;
        logic [N-1:0] dl;
        int           cyc;
    } exp_t;

    exp_t sb[$];
    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // reference: call c<N is UP floor c, c>=N is DOWN floor c-N
    int          run [NC];
    int          hist[NC][4];
    call_state_t st  [NC];
    int          tm  [NC];

    function automatic void model_reset();
        for (int c = 0; c < NC; c++) begin
            run[c] = 0;
            st[c]  = IDLE;
            tm[c]  = 0;
            for (int k = 0; k < 4; k++) hist[c][k] = 0;
        end
    endfunction

    task automatic model_step();
        exp_t e;
        logic btn, sts, press;
        if (!reset_n) begin
            model_reset();
        end else begin
            for (int c = 0; c < NC; c++) begin
                btn = (c < N) ? up_btn[c] : dn_btn[c-N];
                sts = (c < N) ? up_status[c] : dn_status[c-N];
                // a press fires 4 edges after the held run first reaches DB samples
                press = (hist[c][3] == DB);
                for (int k = 3; k > 0; k--) hist[c][k] = hist[c][k-1];
                run[c] = btn ? run[c] + 1 : 0;
                hist[c][0] = run[c];
                if (c == N - 1 || c == N) continue;
                case (st[c])
                    IDLE:     if (press) begin st[c] = sts ? ASSIGNED : PENDING; tm[c] = 0; end
                    PENDING:  if (sts) st[c] = ASSIGNED;
                              else if (tm[c] == TO - 1) st[c] = RETRY;
                              else tm[c] = tm[c] + 1;
                    ASSIGNED: if (!sts) st[c] = IDLE;
                    RETRY:    begin st[c] = sts ? ASSIGNED : PENDING; tm[c] = 0; end
                    default:  st[c] = IDLE;
                endcase
            end
        end
        for (int f = 0; f < N; f++) begin
            e.ur[f] = (st[f] == PENDING);
            e.ul[f] = (st[f] != IDLE);
            e.dr[f] = (st[f+N] == PENDING);
            e.dl[f] = (st[f+N] != IDLE);
        end
        e.cyc = cyc;
        sb.push_back(e);
    endtask

    task automatic check(input string name, input logic [N-1:0] act,
                         input logic [N-1:0] req, input int cy);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s cycle=%0d actual=%h required=%h", name, cy, act, req);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("up_rqst", up_rqst, e.ur, e.cyc);
            check("dn_rqst", dn_rqst, e.dr, e.cyc);
            check("up_lamp", up_lamp, e.ul, e.cyc);
            check("dn_lamp", dn_lamp, e.dl, e.cyc);
        end
    end

    task automatic tick();
        @(posedge clk);
        model_step();
        cyc++;
        #1;
    endtask

    initial begin
        model_reset();
        reset_n   = 1'b0;
        up_btn    = '0;
        dn_btn    = '0;
        up_status = '0;
        dn_status = '0;
        repeat (3) tick();
        reset_n = 1'b1;
        repeat (6) tick();

        // clean presses, timeout, boundaries held, bouncing dn_btn[5]
        up_btn[3]    = 1'b1;
        up_btn[4]    = 1'b1;
        up_btn[N-1]  = 1'b1;
        dn_btn[0]    = 1'b1;
        for (int i = 0; i < 220; i++) begin
            if (i < 20) dn_btn[5] = ~dn_btn[5];
            else        dn_btn[5] = 1'b0;
            tick();
        end
        up_btn = '0;
        dn_btn = '0;
        repeat (10) tick();

        // handshake: assign, hold, then service
        up_btn[2] = 1'b1;
        repeat (10) tick();
        up_btn[2] = 1'b0;
        repeat (10) tick();
        up_status[2] = 1'b1;
        up_status[3] = 1'b1;
        up_status[4] = 1'b1;
        repeat (20) tick();
        up_status = '0;
        repeat (5) tick();

        // reset with three pending calls and buttons still held
        up_btn[1] = 1'b1;
        up_btn[6] = 1'b1;
        dn_btn[7] = 1'b1;
        repeat (15) tick();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        repeat (20) tick();
        up_btn = '0;
        dn_btn = '0;
        up_status = '1;
        dn_status = '1;
        repeat (3) tick();
        up_status = '0;
        dn_status = '0;
        repeat (3) tick();

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            for (int b = 0; b < N; b++) begin
                if ($urandom_range(15) == 0) up_btn[b] = ~up_btn[b];
                if ($urandom_range(15) == 0) dn_btn[b] = ~dn_btn[b];
                if ($urandom_range(39) == 0) up_status[b] = ~up_status[b];
                if ($urandom_range(39) == 0) dn_status[b] = ~dn_status[b];
            end
            reset_n = ($urandom_range(999) != 0);
            tick();
        end
        reset_n = 1'b1;
        repeat (4) tick();

        for (int k = 0; k < 10 && sb.size() > 0; k++) @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain pending=%0d required=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hall_call_register.md
HALL_CALL_REGISTER -- requirements
Module: hall_call_register

Interface
REQ-001 Parameter: N_FLOORS, 12, number of floors; bit f of every vector is floor f.
REQ-002 Parameter: DEBOUNCE_CYCLES, 4, consecutive high samples needed to accept a press (>=1).
REQ-003 Parameter: ASSIGN_TIMEOUT, 64, cycles a call may stay unacknowledged in PENDING before a retry (>=2).
REQ-004 clk  in  1  single clock; all logic on posedge clk.
REQ-005 reset_n  in  1  reset, synchronous and active-low.
REQ-006 up_btn  in  N_FLOORS  raw hall UP buttons, asynchronous, bouncy, level-high while pressed.
REQ-007 dn_btn  in  N_FLOORS  raw hall DOWN buttons, same semantics as up_btn.
REQ-008 up_status  in  N_FLOORS  global UP request status from the downstream arbiter; high = some lift has taken the call.
REQ-009 dn_status  in  N_FLOORS  global DOWN request status from the downstream arbiter.
REQ-010 up_rqst  out  N_FLOORS  registered UP call requests to the arbiter.
REQ-011 dn_rqst  out  N_FLOORS  registered DOWN call requests to the arbiter.
REQ-012 up_lamp  out  N_FLOORS  registered UP hall-lantern acknowledge lamps.
REQ-013 dn_lamp  out  N_FLOORS  registered DOWN hall-lantern acknowledge lamps.

Function
REQ-014 Each of the 2*N_FLOORS calls is handled by one independent cell: a 2-flop synchronizer, then a debouncer, then a call FSM.
REQ-015 Debounce: a saturating counter increments on each high synchronized sample and clears on any low sample; the debounced level goes high when the count reaches DEBOUNCE_CYCLES and goes low on the first low sample.
REQ-016 Press event: a one-cycle pulse on the rising edge of the debounced level; holding the button produces no further events.
REQ-017 FSM states: IDLE, PENDING, ASSIGNED, RETRY.
REQ-018 IDLE + press event: go to PENDING if status is low; go to ASSIGNED if status is already high.
REQ-019 PENDING: rqst=1, lamp=1, timer increments each cycle; status high -> ASSIGNED, timer cleared.
REQ-020 PENDING with timer == ASSIGN_TIMEOUT-1 and status low -> RETRY.
REQ-021 RETRY lasts exactly 1 cycle: rqst=0, lamp=1; then PENDING with timer=0 (status high during RETRY -> ASSIGNED).
REQ-022 ASSIGNED: rqst=0, lamp=1; status falling to low -> IDLE (call serviced).
REQ-023 IDLE: rqst=0, lamp=0; status high without a press keeps the cell in IDLE.
REQ-024 Press events in PENDING, ASSIGNED or RETRY are ignored (no double registration).
REQ-025 Same-cycle status fall and press event in ASSIGNED: the cell goes to IDLE and the press is dropped.
REQ-026 Boundary floors: up_btn[N_FLOORS-1] and dn_btn[0] are ignored; their rqst and lamp bits are tied to 0.
REQ-027 Latency: if the button is held clean high, rqst rises 2 (sync) + DEBOUNCE_CYCLES + 1 cycles after the first sampled-high edge.
REQ-028 rqst and lamp outputs come straight from flops; there is no combinational path from inputs to outputs.

Reset
REQ-029 While reset_n is low at a clk edge, all of the following are cleared: every FSM goes to IDLE, timers and debounce counters go to 0, synchronizers go to 0, and every output goes to 0.
REQ-030 Reset asserted mid-operation discards all pending and assigned calls; there is no recovery of calls after release.
REQ-031 After reset_n is released, a button that is still held needs a fresh full debounce before it creates a press event.

Structure
REQ-032 The shared package lift_pkg holds call_state_t (IDLE, PENDING, ASSIGNED, RETRY) and the default values of N_FLOORS, DEBOUNCE_CYCLES and ASSIGN_TIMEOUT.
REQ-033 Sub-module hall_call_cell (synchronizer + debouncer + FSM + timer) is instantiated via generate, once per UP call and once per DOWN call.
REQ-034 The timer width is $clog2(ASSIGN_TIMEOUT), and the debounce counter width is $clog2(DEBOUNCE_CYCLES+1).

Verification
REQ-035 Clean press: up_btn[3] is held high from cycle 10, status stays 0 -> up_rqst[3] and up_lamp[3] rise at cycle 17 with default parameters.
REQ-036 Bounce: dn_btn[5] toggles high/low every cycle for 20 cycles -> dn_rqst[5] stays 0 throughout.
REQ-037 Handshake: during PENDING, up_status[2] is driven high at cycle 30 -> at cycle 31 up_rqst[2]=0 and up_lamp[2]=1; up_status[2] drops at cycle 50 -> up_lamp[2]=0 at cycle 51.
REQ-038 Timeout: up_btn[4] is pressed and status never rises -> up_rqst[4] drops for exactly 1 cycle every 65 cycles while up_lamp[4] stays 1.
REQ-039 Boundaries: up_btn[11] and dn_btn[0] are held for 100 cycles -> the corresponding rqst and lamp bits stay 0.
REQ-040 Reset mid-operation: 3 calls are PENDING when reset_n is driven low for 1 cycle -> all outputs are 0 on the next cycle, and buttons still held re-register only after a full debounce.
